// File: rtl/i2c_arbiter_if.sv
// Requester and transaction-engine signals of the I2C arbiter, bundled for port connection.
// The master modport is the arbiter's view; slave is the view of whatever drives it.
interface i2c_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   i_req;
  logic [NUM_REQ-1:0]   i_we;
  logic [7*NUM_REQ-1:0] i_addr;
  logic [8*NUM_REQ-1:0] i_reg;
  logic [8*NUM_REQ-1:0] i_wdata;
  logic [NUM_REQ-1:0]   o_grant;
  logic [NUM_REQ-1:0]   o_ack;
  logic                 o_err;
  logic [7:0]           o_rdata;
  logic                 o_busy;
  logic                 o_begin;
  logic                 o_writeEnable;
  logic [6:0]           o_i2cAddress;
  logic [7:0]           o_regAddress;
  logic [7:0]           o_txData;
  logic [7:0]           i_rxData;
  logic                 i_done;

  modport master (
    input  i_req, i_we, i_addr, i_reg, i_wdata, i_rxData, i_done,
    output o_grant, o_ack, o_err, o_rdata, o_busy, o_begin,
           o_writeEnable, o_i2cAddress, o_regAddress, o_txData
  );

  modport slave (
    output i_req, i_we, i_addr, i_reg, i_wdata, i_rxData, i_done,
    input  o_grant, o_ack, o_err, o_rdata, o_busy, o_begin,
           o_writeEnable, o_i2cAddress, o_regAddress, o_txData
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C transaction engine between NUM_REQ requesters,
// with a watchdog that ends a hung transaction with an error acknowledge.
//   state | meaning
//   IDLE  | no transaction; pick next requester round-robin from ptr
//   WAIT  | command latched, begin held high until done or timeout
//   RESP  | one-cycle ack (with err) to the granted requester
module i2c_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic           i_clk,
  input logic           i_rst_n,
  i2c_arbiter_if.master bus
);
  localparam int PW  = $clog2(NUM_REQ);
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW:0]   NUM_REQ_W = PW1'(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TERM_CNT  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state, stateNext;
  logic [PW-1:0]        ptr, ptrNext, grantIdx, grantIdxNext, pickIdx;
  logic [PW:0]          cand;
  logic                 found;
  logic [CW-1:0]        cnt, cntNext;
  logic [NUM_REQ-1:0]   grantQ, grantNext, ackQ, ackNext;
  logic                 errQ, errNext, busyQ, busyNext, beginQ, beginNext, weQ, weNext;
  logic [7:0]           rdataQ, rdataNext, regQ, regNext, txQ, txNext;
  logic [6:0]           addrQ, addrNext;

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    pickIdx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + PW1'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && bus.i_req[cand[PW-1:0]]) begin
        found   = 1'b1;
        pickIdx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    stateNext    = state;
    ptrNext      = ptr;
    grantIdxNext = grantIdx;
    cntNext      = cnt;
    grantNext    = grantQ;
    ackNext      = ackQ;
    errNext      = errQ;
    rdataNext    = rdataQ;
    busyNext     = busyQ;
    beginNext    = beginQ;
    weNext       = weQ;
    addrNext     = addrQ;
    regNext      = regQ;
    txNext       = txQ;
    case (state)
      IDLE: begin
        if (found) begin
          grantNext          = '0;
          grantNext[pickIdx] = 1'b1;
          grantIdxNext       = pickIdx;
          weNext             = bus.i_we[pickIdx];
          addrNext           = bus.i_addr[int'(pickIdx)*7 +: 7];
          regNext            = bus.i_reg[int'(pickIdx)*8 +: 8];
          txNext             = bus.i_wdata[int'(pickIdx)*8 +: 8];
          beginNext          = 1'b1;
          busyNext           = 1'b1;
          cntNext            = '0;
          stateNext          = WAIT;
        end
      end
      WAIT: begin
        cntNext = cnt + 1'b1;
        // Begin drops on the done edge so the engine is back in idle with begin low.
        if (bus.i_done) begin
          beginNext = 1'b0;
          rdataNext = bus.i_rxData;
          errNext   = 1'b0;
          ackNext   = grantQ;
          stateNext = RESP;
        end else if (cnt == TERM_CNT) begin
          beginNext = 1'b0;
          errNext   = 1'b1;
          ackNext   = grantQ;
          stateNext = RESP;
        end
      end
      RESP: begin
        ackNext   = '0;
        grantNext = '0;
        errNext   = 1'b0;
        busyNext  = 1'b0;
        ptrNext   = (grantIdx == LAST_IDX) ? '0 : grantIdx + 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grantIdx <= '0;
      cnt      <= '0;
      grantQ   <= '0;
      ackQ     <= '0;
      errQ     <= 1'b0;
      rdataQ   <= '0;
      busyQ    <= 1'b0;
      beginQ   <= 1'b0;
      weQ      <= 1'b0;
      addrQ    <= '0;
      regQ     <= '0;
      txQ      <= '0;
    end else begin
      state    <= stateNext;
      ptr      <= ptrNext;
      grantIdx <= grantIdxNext;
      cnt      <= cntNext;
      grantQ   <= grantNext;
      ackQ     <= ackNext;
      errQ     <= errNext;
      rdataQ   <= rdataNext;
      busyQ    <= busyNext;
      beginQ   <= beginNext;
      weQ      <= weNext;
      addrQ    <= addrNext;
      regQ     <= regNext;
      txQ      <= txNext;
    end
  end

  assign bus.o_grant       = grantQ;
  assign bus.o_ack         = ackQ;
  assign bus.o_err         = errQ;
  assign bus.o_rdata       = rdataQ;
  assign bus.o_busy        = busyQ;
  assign bus.o_begin       = beginQ;
  assign bus.o_writeEnable = weQ;
  assign bus.o_i2cAddress  = addrQ;
  assign bus.o_regAddress  = regQ;
  assign bus.o_txData      = txQ;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: write, read, contention, timeout, reset and long begin hold.
// A second instance with a long watchdog covers the slow-handler case.
module tb_i2c_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  i2c_arbiter_if #(.NUM_REQ(3)) bus ();
  i2c_arbiter_if #(.NUM_REQ(3)) busL ();

  i2c_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(100)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.master)
  );

  i2c_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(1000)) dutL (
    .i_clk(clk), .i_rst_n(rst_n), .bus(busL.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setReq(input int k, input logic we, input logic [6:0] addr,
                        input logic [7:0] rg, input logic [7:0] wd);
    bus.i_we[k]          = we;
    bus.i_addr[7*k +: 7] = addr;
    bus.i_reg[8*k +: 8]  = rg;
    bus.i_wdata[8*k +: 8] = wd;
  endtask

  task automatic waitBegin(input string tag);
    int n = 0;
    while (bus.o_begin !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.o_begin, 1);
  endtask

  task automatic pulseDone(input logic [7:0] rx);
    bus.i_rxData = rx;
    bus.i_done   = 1'b1;
    @(negedge clk);
    bus.i_done   = 1'b0;
  endtask

  initial begin
    int n;
    int lowSeen;
    logic [2:0] expG;
    bus.i_req = '0;  bus.i_we = '0;  bus.i_addr = '0;  bus.i_reg = '0;
    bus.i_wdata = '0; bus.i_rxData = '0; bus.i_done = 1'b0;
    busL.i_req = '0; busL.i_we = '0; busL.i_addr = '0; busL.i_reg = '0;
    busL.i_wdata = '0; busL.i_rxData = '0; busL.i_done = 1'b0;

    // Reset values
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", bus.o_grant, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_begin", bus.o_begin, 0);
    check("rst_ack", bus.o_ack, 0);
    check("rst_rdata", bus.o_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write from requester 0, done after 50 cycles
    setReq(0, 1'b1, 7'h48, 8'h01, 8'hA5);
    bus.i_req = 3'b001;
    @(negedge clk);
    check("wr_begin_lat", bus.o_begin, 1);
    check("wr_grant", bus.o_grant, 3'b001);
    check("wr_we", bus.o_writeEnable, 1);
    check("wr_addr", bus.o_i2cAddress, 7'h48);
    check("wr_reg", bus.o_regAddress, 8'h01);
    check("wr_tx", bus.o_txData, 8'hA5);
    check("wr_busy", bus.o_busy, 1);
    repeat (49) @(negedge clk);
    check("wr_ack_early", bus.o_ack, 0);
    pulseDone(8'h00);
    check("wr_ack", bus.o_ack, 3'b001);
    check("wr_err", bus.o_err, 0);
    check("wr_begin_low", bus.o_begin, 0);
    bus.i_req = '0;
    @(negedge clk);
    check("wr_ack_1cyc", bus.o_ack, 0);
    check("wr_idle_busy", bus.o_busy, 0);
    check("wr_idle_grant", bus.o_grant, 0);

    // Read from requester 1; request dropped mid-transaction still completes
    setReq(1, 1'b0, 7'h20, 8'h10, 8'h00);
    bus.i_req = 3'b010;
    @(negedge clk);
    check("rd_grant", bus.o_grant, 3'b010);
    check("rd_we", bus.o_writeEnable, 0);
    check("rd_addr", bus.o_i2cAddress, 7'h20);
    check("rd_reg", bus.o_regAddress, 8'h10);
    repeat (2) @(negedge clk);
    bus.i_req = '0;
    repeat (2) @(negedge clk);
    pulseDone(8'h3C);
    check("rd_ack", bus.o_ack, 3'b010);
    check("rd_data", bus.o_rdata, 8'h3C);
    repeat (3) @(negedge clk);
    check("rd_data_hold", bus.o_rdata, 8'h3C);

    // Contention from reset: pointer back at 0, strict rotation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    setReq(2, 1'b1, 7'h55, 8'h22, 8'h33);
    bus.i_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      waitBegin("rr_begin");
      expG = 3'b001 << (k % 3);
      check("rr_grant", bus.o_grant, expG);
      repeat (2) @(negedge clk);
      pulseDone(8'h50 + 8'(k));
      check("rr_ack", bus.o_ack, expG);
      check("rr_rdata", bus.o_rdata, 8'h50 + 8'(k));
    end

    // Timeout: no done, begin high for exactly 100 cycles
    bus.i_req = 3'b001;
    waitBegin("to_begin");
    n = 0;
    while (bus.o_begin === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("to_cycles", n, 100);
    check("to_ack", bus.o_ack, 3'b001);
    check("to_err", bus.o_err, 1);
    check("to_rdata", bus.o_rdata, 8'h55);
    bus.i_req = '0;
    repeat (10) @(negedge clk);
    pulseDone(8'hEE);
    check("late_rdata", bus.o_rdata, 8'h55);
    check("late_ack", bus.o_ack, 0);
    check("late_busy", bus.o_busy, 0);

    // Asynchronous reset mid-WAIT
    bus.i_req = 3'b001;
    waitBegin("mr_begin");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_begin", bus.o_begin, 0);
    check("mr_grant", bus.o_grant, 0);
    check("mr_busy", bus.o_busy, 0);
    bus.i_req = 3'b100;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_req2_grant", bus.o_grant, 3'b100);
    check("mr_req2_addr", bus.o_i2cAddress, 7'h55);
    repeat (3) @(negedge clk);
    pulseDone(8'h77);
    check("mr_req2_ack", bus.o_ack, 3'b100);
    check("mr_req2_rdata", bus.o_rdata, 8'h77);
    bus.i_req = '0;
    @(negedge clk);

    // Begin held through a 300-cycle handler init on the long-watchdog instance
    busL.i_we[0] = 1'b1;
    busL.i_addr[6:0] = 7'h11;
    busL.i_reg[7:0] = 8'h02;
    busL.i_wdata[7:0] = 8'h5A;
    busL.i_req = 3'b001;
    @(negedge clk);
    check("bh_begin", busL.o_begin, 1);
    lowSeen = 0;
    repeat (299) begin
      @(negedge clk);
      if (busL.o_begin !== 1'b1) lowSeen++;
    end
    check("bh_held", lowSeen, 0);
    busL.i_rxData = 8'h00;
    busL.i_done = 1'b1;
    @(negedge clk);
    busL.i_done = 1'b0;
    check("bh_drop", busL.o_begin, 0);
    check("bh_ack", busL.o_ack, 3'b001);
    check("bh_err", busL.o_err, 0);
    busL.i_req = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
